// File: rtl/lift_pkg.sv
// lift_pkg: shared direction codes, car state encoding and sizing helpers for the lift car drive
package lift_pkg;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;
  localparam logic [1:0] DIR_REST = 2'b00;
  localparam logic [1:0] DIR_INV  = 2'b11;
  localparam int LIFT_NUM_FLOORS = 5;
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_MOVE       = 2'd1,
    S_DOOR_OPEN  = 2'd2,
    S_DOOR_CLOSE = 2'd3
  } state_e;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/lift_timer.sv
// lift_timer: loadable down-counter that sticks at zero and flags it; shared by travel, door and close phases
module lift_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_d, cnt_q;
  // a load overrides counting; otherwise count down and rest at zero
  always_comb cnt_d = load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - W'(1));
  // count register, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/lift_car_drive.sv
// lift_car_drive: car-side executor of controller stop commands; optional door hold via LIFT_DOOR_HOLD_EN
module lift_car_drive
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = LIFT_NUM_FLOORS,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  parameter int CLOSE_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  input  logic [1:0]            cmd_dir,
  input  logic [FLOOR_W-1:0]    cmd_floor,
  output logic [FLOOR_W-1:0]    curr_floor,
  output logic [1:0]            car_dir,
  output logic                  car_moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] clr_floor,
  output logic [NUM_FLOORS-2:0] clr_up,
  output logic [NUM_FLOORS-2:0] clr_down,
  output logic                  cmd_err
);
  localparam int CNT_W = $clog2(max3(TRAVEL_CYCLES, DOOR_CYCLES, CLOSE_CYCLES));
  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLOSE_LD  = CNT_W'(CLOSE_CYCLES - 1);
  state_e               state_d, state_q;
  logic [FLOOR_W-1:0]   floor_d, floor_q;
  logic [1:0]           dir_d, dir_q;
  logic                 arrived_d, arrived_q;
  logic                 err_d, err_q;
  logic                 ld, zero, oor, ahead;
  logic [CNT_W-1:0]     ld_val;
  logic [FLOOR_W-1:0]   nf;
  logic [NUM_FLOORS-1:0] hot;
  lift_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );
  assign oor   = {1'b0, cmd_floor} >= (FLOOR_W + 1)'(NUM_FLOORS);
  assign nf    = dir_q == DIR_UP ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
  assign ahead = dir_q == DIR_UP ? cmd_floor > nf : cmd_floor < nf;
  // next state: command acceptance in IDLE, boundary decisions in MOVE, door open/close timing
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    arrived_d = 1'b0;
    err_d     = 1'b0;
    ld        = 1'b0;
    ld_val    = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_dir == DIR_INV || oor) err_d = 1'b1;
        else if (cmd_floor == floor_q) begin
          if (cmd_dir != DIR_REST) begin
            state_d   = S_DOOR_OPEN;
            arrived_d = 1'b1;
            ld        = 1'b1;
            ld_val    = DOOR_LD;
          end
        end else if ((cmd_dir == DIR_UP && cmd_floor > floor_q) || (cmd_dir == DIR_DOWN && cmd_floor < floor_q)) begin
          state_d = S_MOVE;
          dir_d   = cmd_dir;
          ld      = 1'b1;
          ld_val  = TRAVEL_LD;
        end else if (cmd_dir != DIR_REST) err_d = 1'b1;
      end
      S_MOVE: begin
        if (zero) begin
          floor_d = nf;
          if (cmd_floor == nf) begin
            state_d   = S_DOOR_OPEN;
            dir_d     = DIR_REST;
            arrived_d = 1'b1;
            ld        = 1'b1;
            ld_val    = DOOR_LD;
          end else if (cmd_dir == dir_q && ahead && !oor) begin
            ld     = 1'b1;
            ld_val = TRAVEL_LD;
          end else begin
            state_d = S_IDLE;
            dir_d   = DIR_REST;
            err_d   = cmd_dir == DIR_UP && dir_q == DIR_UP && oor;
          end
        end
      end
      S_DOOR_OPEN: begin
`ifdef LIFT_DOOR_HOLD_EN
        if (door_hold) begin
          ld     = 1'b1;
          ld_val = DOOR_LD;
        end else
`endif
        if (zero) begin
          state_d = S_DOOR_CLOSE;
          ld      = 1'b1;
          ld_val  = CLOSE_LD;
        end
      end
      default: begin
`ifdef LIFT_DOOR_HOLD_EN
        if (door_hold) begin
          state_d = S_DOOR_OPEN;
          ld      = 1'b1;
          ld_val  = DOOR_LD;
        end else
`endif
        if (zero) state_d = S_IDLE;
      end
    endcase
  end
  // car state registers, all returned to idle at floor 0 by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_REST;
      arrived_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      arrived_q <= arrived_d;
      err_q     <= err_d;
    end
  end
  assign hot        = arrived_q ? NUM_FLOORS'(1) << floor_q : '0;
  assign clr_floor  = hot;
  assign clr_up     = hot[NUM_FLOORS-2:0];
  assign clr_down   = hot[NUM_FLOORS-1:1];
  assign curr_floor = floor_q;
  assign car_dir    = dir_q;
  assign car_moving = state_q == S_MOVE;
  assign door_open  = state_q == S_DOOR_OPEN;
  assign arrived    = arrived_q;
  assign cmd_err    = err_q;
endmodule

// File: tb/tb_lift_car_drive.sv
// tb_lift_car_drive: directed and random checks of lift_car_drive against a cycle-level behavioural model
module tb_lift_car_drive;
  localparam int NF = 5;
  localparam int TC = 4;
  localparam int DC = 8;
  localparam int CC = 2;
  localparam logic [1:0] UP = 2'b10, DN = 2'b01, RST = 2'b00, INV = 2'b11;
`ifdef LIFT_DOOR_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic door_hold = 1'b0;
  logic [1:0] cmd_dir = 2'b00;
  logic [2:0] cmd_floor = 3'd0;
  logic [2:0] curr_floor;
  logic [1:0] car_dir;
  logic car_moving, door_open, arrived, cmd_err;
  logic [NF-1:0] clr_floor;
  logic [NF-2:0] clr_up, clr_down;
  int total = 0;
  int bad = 0;
  int mf, mode, left;
  logic [1:0] mdir;
  logic e_arr, e_err;
  int cnt;
  lift_car_drive dut (
    .clk        (clk),
    .reset      (reset),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold  (door_hold),
`endif
    .cmd_dir    (cmd_dir),
    .cmd_floor  (cmd_floor),
    .curr_floor (curr_floor),
    .car_dir    (car_dir),
    .car_moving (car_moving),
    .door_open  (door_open),
    .arrived    (arrived),
    .clr_floor  (clr_floor),
    .clr_up     (clr_up),
    .clr_down   (clr_down),
    .cmd_err    (cmd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    mf = 0; mode = 0; left = 0; mdir = RST; e_arr = 1'b0; e_err = 1'b0;
  endtask
  task automatic m_open();
    mode = 2; left = DC; e_arr = 1'b1; mdir = RST;
  endtask
  // one clock edge of the reference behaviour, using the inputs held across that edge
  task automatic m_step();
    int cd, cf;
    cd = int'(cmd_dir); cf = int'(cmd_floor);
    e_arr = 1'b0; e_err = 1'b0;
    if (mode == 0) begin
      if (cd == 3 || cf >= NF) e_err = 1'b1;
      else if (cf == mf) begin
        if (cd != 0) m_open();
      end else if ((cd == int'(UP) && cf > mf) || (cd == int'(DN) && cf < mf)) begin
        mode = 1; mdir = cmd_dir; left = TC;
      end else if (cd != 0) e_err = 1'b1;
    end else if (mode == 1) begin
      left--;
      if (left == 0) begin
        mf += (mdir == UP) ? 1 : -1;
        if (cf == mf) m_open();
        else if (cd == int'(mdir) && ((mdir == UP) ? cf > mf : cf < mf) && cf < NF) left = TC;
        else begin
          e_err = (cd == int'(UP) && mdir == UP && cf >= NF);
          mode = 0; mdir = RST;
        end
      end
    end else if (mode == 2) begin
      left--;
      if (HOLD_ON && door_hold) left = DC;
      else if (left == 0) begin mode = 3; left = CC; end
    end else begin
      left--;
      if (HOLD_ON && door_hold) begin mode = 2; left = DC; end
      else if (left == 0) mode = 0;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".floor"}, 32'(curr_floor), 32'(mf));
    chk({tag, ".dir"}, 32'(car_dir), 32'(mdir));
    chk({tag, ".moving"}, 32'(car_moving), 32'(mode == 1));
    chk({tag, ".door"}, 32'(door_open), 32'(mode == 2));
    chk({tag, ".arrived"}, 32'(arrived), 32'(e_arr));
    chk({tag, ".clr_floor"}, 32'(clr_floor), e_arr ? 32'(1) << mf : 32'(0));
    chk({tag, ".clr_up"}, 32'(clr_up), (e_arr && mf < NF - 1) ? 32'(1) << mf : 32'(0));
    chk({tag, ".clr_down"}, 32'(clr_down), (e_arr && mf > 0) ? 32'(1) << (mf - 1) : 32'(0));
    chk({tag, ".err"}, 32'(cmd_err), 32'(e_err));
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all(tag);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    m_reset();
    #1 check_all("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    m_reset();
    @(negedge clk);
    do_reset();
    // travel 0 -> 3 with spec-given timing and clear pulses
    cmd_dir = UP; cmd_floor = 3'd3;
    tick("go3");
    chk("moving_next_cycle", 32'(car_moving), 32'd1);
    for (int i = 2; i <= 13; i++) begin
      tick("go3");
      if (i == 5) chk("floor1_at5", 32'(curr_floor), 32'd1);
      if (i == 9) chk("floor2_at9", 32'(curr_floor), 32'd2);
    end
    chk("floor3_at13", 32'(curr_floor), 32'd3);
    chk("arrived_at13", 32'(arrived), 32'd1);
    chk("clr_floor_f3", 32'(clr_floor), 32'b01000);
    chk("clr_up_f3", 32'(clr_up), 32'b1000);
    chk("clr_down_f3", 32'(clr_down), 32'b0100);
    cmd_dir = RST;
    cnt = 1;
    for (int i = 0; i < 12; i++) begin
      tick("door3");
      cnt += int'(door_open);
    end
    chk("door_open_cycles", 32'(cnt), 32'(DC));
    // retarget mid-travel: 0 -> 4 becomes 0 -> 2
    do_reset();
    cmd_dir = UP; cmd_floor = 3'd4;
    repeat (6) tick("go4");
    cmd_floor = 3'd2;
    repeat (3) tick("retgt");
    chk("retarget_floor", 32'(curr_floor), 32'd2);
    chk("retarget_door", 32'(door_open), 32'd1);
    cmd_dir = RST;
    repeat (12) tick("door2");
    // rejected commands while idle at floor 2
    cmd_dir = UP; cmd_floor = 3'd1;
    tick("badup");
    chk("badup_err", 32'(cmd_err), 32'd1);
    chk("badup_still", 32'(car_moving), 32'd0);
    cmd_dir = RST;
    tick("rest");
    cmd_dir = INV; cmd_floor = 3'd2;
    tick("inv");
    chk("inv_err", 32'(cmd_err), 32'd1);
    cmd_dir = RST;
    tick("rest");
    // reset between floors 2 and 3
    cmd_dir = UP; cmd_floor = 3'd4;
    repeat (2) tick("go4b");
    do_reset();
    chk("midreset_floor", 32'(curr_floor), 32'd0);
    chk("midreset_moving", 32'(car_moving), 32'd0);
`ifdef LIFT_DOOR_HOLD_EN
    cmd_dir = UP; cmd_floor = 3'd0;
    tick("open0");
    cmd_dir = RST; door_hold = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick("hold");
      cnt += int'(arrived);
      chk("hold_door", 32'(door_open), 32'd1);
    end
    chk("hold_single_arrived", 32'(cnt), 32'd0);
    door_hold = 1'b0;
    repeat (12) tick("unhold");
`endif
    // randomized command stream
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cmd_dir = ($urandom_range(0, 15) == 0) ? INV : 2'($urandom_range(0, 2));
        cmd_floor = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      end
      if (HOLD_ON) door_hold = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
